// File: rtl/zynet_pkg.sv
// Shared definitions for the zynet streaming blocks.
package zynet_pkg;

    // Handshake notes shared by the producer/consumer blocks.
    localparam string HS_READY_NOTE = "ready_o depends on registers only";
    localparam string HS_WEN_NOTE   = "wen_o = data held & ~full_i, one beat per asserted cycle";

    // Bit width needed to count n states, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = $clog2(n);
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vec_bank.sv
// One storage bank of a full activation vector with a beat-select output mux.
module vec_bank #(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned LAYER_HEIGHT = 256,
    parameter int unsigned LANES        = 1,
    parameter int unsigned BEAT_BITS    = 8
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              load_i,
    input  logic [LAYER_HEIGHT*WORD_SIZE-1:0] data_i,
    input  logic [BEAT_BITS-1:0]              beat_i,
    output logic [LANES*WORD_SIZE-1:0]        data_o
);

    localparam int unsigned BEATS = LAYER_HEIGHT / LANES;

    logic [LAYER_HEIGHT*WORD_SIZE-1:0] mem_q;
    logic [LANES*WORD_SIZE-1:0]        beat_words [BEATS];

    // Capture a whole vector when the top selects this bank for filling.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q <= '0;
        end else if (load_i) begin
            mem_q <= data_i;
        end
    end

    for (genvar g = 0; g < BEATS; g++) begin : g_slice
        assign beat_words[g] = mem_q[g*LANES*WORD_SIZE +: LANES*WORD_SIZE];
    end

    // With a single beat the counter is always zero, so no mux is needed.
    if (BEATS == 1) begin : g_one_beat
        assign data_o = beat_words[0];
    end else begin : g_multi_beat
        assign data_o = beat_words[beat_i];
    end

endmodule

// File: rtl/vec_serializer.sv
// Double-buffered parallel-to-serial converter: one vector in, BEATS beats of LANES words out.
module vec_serializer
    import zynet_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned LAYER_HEIGHT = 256,
    parameter int unsigned LANES        = 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic [LAYER_HEIGHT*WORD_SIZE-1:0] data_i,
    output logic                              wen_o,
    input  logic                              full_i,
    output logic [LANES*WORD_SIZE-1:0]        data_o,
    output logic                              last_o
);

    localparam int unsigned BEATS     = LAYER_HEIGHT / LANES;
    localparam int unsigned BEAT_BITS = clog2_min1(BEATS);

    if (LAYER_HEIGHT % LANES != 0) begin : g_bad_lanes
        $error("vec_serializer: LAYER_HEIGHT must be a multiple of LANES");
    end

    logic [1:0]           bank_full_q, bank_full_d;
    logic                 wb_q, wb_d;
    logic                 rb_q, rb_d;
    logic [BEAT_BITS-1:0] beat_q, beat_d;

    logic                       accept;
    logic                       last_beat;
    logic [LANES*WORD_SIZE-1:0] bank_data [2];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        vec_bank #(
            .WORD_SIZE   (WORD_SIZE),
            .LAYER_HEIGHT(LAYER_HEIGHT),
            .LANES       (LANES),
            .BEAT_BITS   (BEAT_BITS)
        ) u_bank (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .load_i (accept && (wb_q == 1'(g))),
            .data_i (data_i),
            .beat_i (beat_q),
            .data_o (bank_data[g])
        );
    end

    // Handshake and beat outputs; full_i reaches wen_o/last_o combinationally.
    always_comb begin
        ready_o   = ~bank_full_q[wb_q];
        accept    = valid_i & ready_o;
        wen_o     = bank_full_q[rb_q] & ~full_i;
        last_beat = (beat_q == BEAT_BITS'(BEATS - 1));
        last_o    = wen_o & last_beat;
        data_o    = bank_data[rb_q];
    end

    // Next-state: drain advances the beat, the final beat frees the read bank;
    // an accept fills the write bank. Both may happen together on different banks.
    always_comb begin
        bank_full_d = bank_full_q;
        wb_d        = wb_q;
        rb_d        = rb_q;
        beat_d      = beat_q;
        if (wen_o) begin
            if (last_beat) begin
                bank_full_d[rb_q] = 1'b0;
                rb_d              = ~rb_q;
                beat_d            = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end
        if (accept) begin
            bank_full_d[wb_q] = 1'b1;
            wb_d              = ~wb_q;
        end
    end

    // Flags, pointers and beat counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bank_full_q <= '0;
            wb_q        <= 1'b0;
            rb_q        <= 1'b0;
            beat_q      <= '0;
        end else begin
            bank_full_q <= bank_full_d;
            wb_q        <= wb_d;
            rb_q        <= rb_d;
            beat_q      <= beat_d;
        end
    end

endmodule

// File: tb/tb_vec_serializer.sv
// Directed bench for vec_serializer: LANES=2 table plus LANES=8 streaming and async reset.
module tb_vec_serializer;

    logic clk = 1'b0;
    logic reset_i;

    always #5 clk = ~clk;

    // DUT with LANES=2 (BEATS=4)
    logic         valid2, full2, ready2, wen2, last2;
    logic [127:0] din2;
    logic [31:0]  dout2;

    // DUT with LANES=8 (BEATS=1)
    logic         valid8, full8, ready8, wen8, last8;
    logic [127:0] din8;
    logic [127:0] dout8;

    vec_serializer #(.WORD_SIZE(16), .LAYER_HEIGHT(8), .LANES(2)) u_dut2 (
        .clk_i  (clk),
        .reset_i(reset_i),
        .valid_i(valid2),
        .ready_o(ready2),
        .data_i (din2),
        .wen_o  (wen2),
        .full_i (full2),
        .data_o (dout2),
        .last_o (last2)
    );

    vec_serializer #(.WORD_SIZE(16), .LAYER_HEIGHT(8), .LANES(8)) u_dut8 (
        .clk_i  (clk),
        .reset_i(reset_i),
        .valid_i(valid8),
        .ready_o(ready8),
        .data_i (din8),
        .wen_o  (wen8),
        .full_i (full8),
        .data_o (dout8),
        .last_o (last8)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Vector with word k = base + k, word 0 in the low bits.
    function automatic logic [127:0] mkvec(input logic [15:0] base);
        logic [127:0] v;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = base + 16'(k);
        return v;
    endfunction

    typedef struct {
        logic        valid;
        logic        full;
        int          vsel;
        logic        ready;
        logic        wen;
        logic        last;
        logic [31:0] data;
    } rec_t;

    rec_t tbl[$];

    function automatic rec_t mk(input logic v, input logic f, input int s,
                                input logic r, input logic w, input logic l,
                                input logic [31:0] d);
        rec_t x;
        x.valid = v; x.full = f; x.vsel = s;
        x.ready = r; x.wen = w; x.last = l; x.data = d;
        return x;
    endfunction

    logic [127:0] vecs [3];

    initial begin
        vecs[0] = mkvec(16'h0001);  // A
        vecs[1] = mkvec(16'h0011);  // B
        vecs[2] = mkvec(16'h0021);  // C

        // Single vector, no backpressure
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0002_0001));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0004_0003));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0006_0005));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0008_0007));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0));
        // Same vector into bank 1, full_i high for three cycles
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0002_0001));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0004_0003));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0004_0003));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 32'h0004_0003));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0004_0003));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'h0006_0005));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 32'h0008_0007));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 32'h0002_0001));  // stale bank 0 shown, no strobe
        // A, B, C with valid held: 12 contiguous beats
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 32'h0002_0001));
        tbl.push_back(mk(1, 0, 1, 1, 1, 0, 32'h0002_0001));
        tbl.push_back(mk(1, 0, 2, 0, 1, 0, 32'h0004_0003));
        tbl.push_back(mk(1, 0, 2, 0, 1, 0, 32'h0006_0005));
        tbl.push_back(mk(1, 0, 2, 0, 1, 1, 32'h0008_0007));
        tbl.push_back(mk(1, 0, 2, 1, 1, 0, 32'h0012_0011));
        tbl.push_back(mk(0, 0, 2, 0, 1, 0, 32'h0014_0013));
        tbl.push_back(mk(0, 0, 2, 0, 1, 0, 32'h0016_0015));
        tbl.push_back(mk(0, 0, 2, 0, 1, 1, 32'h0018_0017));
        tbl.push_back(mk(0, 0, 2, 1, 1, 0, 32'h0022_0021));
        tbl.push_back(mk(0, 0, 2, 1, 1, 0, 32'h0024_0023));
        tbl.push_back(mk(0, 0, 2, 1, 1, 0, 32'h0026_0025));
        tbl.push_back(mk(0, 0, 2, 1, 1, 1, 32'h0028_0027));
        tbl.push_back(mk(0, 0, 2, 1, 0, 0, 32'h0012_0011));

        reset_i = 1'b1;
        valid2 = 0; full2 = 0; din2 = '0;
        valid8 = 0; full8 = 0; din8 = '0;
        #23;
        reset_i = 1'b0;
        #1;
        chk("rst_ready", ready2, 1);
        chk("rst_wen", wen2, 0);
        chk("rst_last", last2, 0);
        chk("rst_data", dout2, 0);
        chk("rst_ready8", ready8, 1);
        chk("rst_wen8", wen8, 0);

        @(posedge clk); #1;
        for (int i = 0; i < tbl.size(); i++) begin
            valid2 = tbl[i].valid;
            full2  = tbl[i].full;
            din2   = vecs[tbl[i].vsel];
            #1;
            chk($sformatf("row%0d_ready", i), ready2, tbl[i].ready);
            chk($sformatf("row%0d_wen", i), wen2, tbl[i].wen);
            chk($sformatf("row%0d_last", i), last2, tbl[i].last);
            chk($sformatf("row%0d_data", i), dout2, tbl[i].data);
            @(posedge clk); #1;
        end
        valid2 = 0; full2 = 0;

        // Async reset mid-drain of the second beat
        din2 = vecs[0]; valid2 = 1; #1;
        chk("ar_accept_ready", ready2, 1);
        @(posedge clk); #1;
        valid2 = 0; #1;
        chk("ar_beat1", dout2, 32'h0002_0001);
        @(posedge clk); #1;
        chk("ar_beat2", dout2, 32'h0004_0003);
        chk("ar_beat2_wen", wen2, 1);
        #2 reset_i = 1'b1;
        #1;
        chk("ar_ready", ready2, 1);
        chk("ar_wen", wen2, 0);
        chk("ar_last", last2, 0);
        chk("ar_data", dout2, 0);
        #2 reset_i = 1'b0;
        @(posedge clk); #1;
        din2 = mkvec(16'h0100); valid2 = 1; #1;
        chk("ar_new_ready", ready2, 1);
        chk("ar_new_idle", wen2, 0);
        @(posedge clk); #1;
        valid2 = 0; #1;
        chk("ar_new_wen", wen2, 1);
        chk("ar_new_data0", dout2, 32'h0101_0100);
        chk("ar_new_last", last2, 0);
        @(posedge clk); #1;
        chk("ar_new_data1", dout2, 32'h0103_0102);

        // LANES=8: one vector per cycle, every beat is last
        for (int n = 0; n < 6; n++) begin
            valid8 = 1;
            din8   = mkvec(16'h1000 + 16'(n * 16));
            #1;
            chk($sformatf("l8_%0d_ready", n), ready8, 1);
            chk($sformatf("l8_%0d_wen", n), wen8, (n > 0));
            chk($sformatf("l8_%0d_last", n), last8, (n > 0));
            if (n > 0) chk($sformatf("l8_%0d_data", n), dout8, mkvec(16'h1000 + 16'((n - 1) * 16)));
            @(posedge clk); #1;
        end
        valid8 = 0; #1;
        chk("l8_tail_wen", wen8, 1);
        chk("l8_tail_last", last8, 1);
        chk("l8_tail_data", dout8, mkvec(16'h1050));
        @(posedge clk); #1;
        chk("l8_drained_wen", wen8, 0);
        chk("l8_drained_ready", ready8, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
